// File: rtl/p_bus_change_capture_if.sv
// p_bus_change_capture_if
//   Bundles the monitored bus, the sampling enable, the record drain
//   handshake and the end-of-test status of p_bus_change_capture.
//   slave  : capture block side (samples p_in, drives the record stream)
//   master : producer/consumer side (drives p_in, en, out_ready)
//   Signals:
//     en        sampling enable
//     p_in      6-bit monitored bus, flat bit 5 = p_in[2][0] ... bit 0 = p_in[4][1]
//     out_valid head record available
//     out_ready consumer accepts the head record
//     out_data  head record bus value
//     out_ts    head record timestamp
//     chg_cnt   saturating count of detected changes
//     ovf       sticky flag: a change was dropped on a full FIFO
interface p_bus_change_capture_if #(
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
);
  logic             en;
  bit   [2:4][0:1]  p_in;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_data;
  logic [TS_W-1:0]  out_ts;
  logic [CNT_W-1:0] chg_cnt;
  logic             ovf;

  modport slave (
    input  en, p_in, out_ready,
    output out_valid, out_data, out_ts, chg_cnt, ovf
  );

  modport master (
    output en, p_in, out_ready,
    input  out_valid, out_data, out_ts, chg_cnt, ovf
  );
endinterface

// File: rtl/p_bus_change_capture.sv
// p_bus_change_capture
//   Samples the 6-bit bus p_in on every enabled clock, detects value
//   changes against the previously sampled value, and queues each change
//   as a {value, timestamp} record in a DEPTH-entry circular FIFO that
//   drains through a valid/ready handshake. A saturating change counter
//   and a sticky overflow flag support end-of-test reporting.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  p_bus_change_capture_if.slave (en, p_in, out_ready in;
//          out_valid, out_data, out_ts, chg_cnt, ovf out)
//   Outputs depend only on registers, so p_in never reaches them
//   combinationally.
module p_bus_change_capture #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  p_bus_change_capture_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } state_t;

  state_t           state;
  logic [5:0]       sample;
  logic [5:0]       prev;
  logic [TS_W-1:0]  ts;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic [5:0]       mem_data [DEPTH];
  logic [TS_W-1:0]  mem_ts   [DEPTH];
  logic [CNT_W-1:0] chg_cnt;
  logic             ovf;
  logic             out_valid;
  logic             empty;
  logic             full;
  logic             change;
  logic             pop;
  logic             push;
  logic             drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Occupancy classification from a pointer pair; the wrap bit
  // distinguishes full from empty when the index bits coincide.
  function automatic state_t occ_state(input logic [AW:0] wp, input logic [AW:0] rp);
    if (wp == rp)
      return S_EMPTY;
    else if ((wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]))
      return S_FULL;
    else
      return S_PARTIAL;
  endfunction

  // p_in is 2-state bit; packed order already yields flat bit 5..0.
  assign sample = bus.p_in;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign change = bus.en && (sample != prev);
  assign pop    = out_valid && bus.out_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  always_comb begin
    wr_ptr_nxt = wr_ptr + (AW+1)'(push);
    rd_ptr_nxt = rd_ptr + (AW+1)'(pop);
  end

  // ---- sample stage: timestamp, previous value, counters, pointers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ts      <= '0;
      prev    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      chg_cnt <= '0;
      ovf     <= 1'b0;
      state   <= S_EMPTY;
    end else begin
      if (bus.en) begin
        ts   <= ts + 1'b1;
        prev <= sample;
      end
      if (change)
        chg_cnt <= sat_inc(chg_cnt);
      if (drop)
        ovf <= 1'b1;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      state  <= occ_state(wr_ptr_nxt, rd_ptr_nxt);
    end
  end

  // Record storage carries no reset; stale slots are never exposed
  // because the outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= sample;
      mem_ts[wr_ptr[AW-1:0]]   <= ts;
    end
  end

  // ---- output stage: head of FIFO ----
  // state mirrors the pointer-derived occupancy, so out_valid == !empty.
  assign out_valid     = (state != S_EMPTY);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
  assign bus.out_ts    = out_valid ? mem_ts[rd_ptr[AW-1:0]] : '0;
  assign bus.chg_cnt   = chg_cnt;
  assign bus.ovf       = ovf;

  // empty is kept as the pointer-level view for readability of the
  // handshake logic; tie it into an assertion-free use here.
  logic unused_empty;
  assign unused_empty = empty;

endmodule

// File: tb/tb_p_bus_change_capture.sv
// tb_p_bus_change_capture
//   Directed bench for p_bus_change_capture with DEPTH=4, TS_W=4, CNT_W=4,
//   so timestamp wrap and counter saturation are reachable quickly.
module tb_p_bus_change_capture;

  localparam int DEPTH = 4;
  localparam int TS_W  = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  p_bus_change_capture_if #(.TS_W(TS_W), .CNT_W(CNT_W)) bus ();

  p_bus_change_capture #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [5:0] exp_d [4];
  logic [3:0] exp_t [4];
  int         cnt;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.p_in = 6'b000000;
    bus.out_ready = 1'b0;

    // Reset for 2 cycles
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ts", bus.out_ts, 0);
    chk("rst_cnt", bus.chg_cnt, 0);
    chk("rst_ovf", bus.ovf, 0);

    // First samples equal to 0: no record, ts advances 0..2 -> 3
    rst = 1'b0;
    bus.en = 1'b1;
    bus.p_in = 6'b000000;
    tick();
    tick();
    tick();
    chk("zero_valid", bus.out_valid, 0);
    chk("zero_cnt", bus.chg_cnt, 0);

    // Single change at ts=3 with consumer stalled
    bus.p_in = 6'b101101;
    tick();
    chk("single_valid", bus.out_valid, 1);
    chk("single_data", bus.out_data, 6'h2d);
    chk("single_ts", bus.out_ts, 3);
    chk("single_cnt", bus.chg_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, 6'h2d);
      chk("hold_ts", bus.out_ts, 3);
    end
    // ts is now 9; pop at this edge
    bus.out_ready = 1'b1;
    tick();
    chk("pop_valid", bus.out_valid, 0);
    chk("pop_cnt", bus.chg_cnt, 1);

    // Fill exactly to DEPTH: records {00,10} {3f,11} {00,12} {3f,13}
    bus.out_ready = 1'b0;
    bus.p_in = 6'h00; tick();
    bus.p_in = 6'h3f; tick();
    bus.p_in = 6'h00; tick();
    bus.p_in = 6'h3f; tick();
    chk("full_valid", bus.out_valid, 1);
    chk("full_data", bus.out_data, 6'h00);
    chk("full_ts", bus.out_ts, 10);
    chk("full_ovf", bus.ovf, 0);
    chk("full_cnt", bus.chg_cnt, 5);

    // Full, push and pop together at ts=14: no drop, occupancy stays 4
    bus.out_ready = 1'b1;
    bus.p_in = 6'h00;
    tick();
    chk("pp_ovf", bus.ovf, 0);
    chk("pp_data", bus.out_data, 6'h3f);
    chk("pp_ts", bus.out_ts, 11);
    chk("pp_cnt", bus.chg_cnt, 6);

    // Still full, so a change at ts=15 without pop is dropped
    bus.out_ready = 1'b0;
    bus.p_in = 6'h3f;
    tick();
    chk("ovf_set", bus.ovf, 1);
    chk("ovf_cnt", bus.chg_cnt, 7);
    chk("ovf_head_data", bus.out_data, 6'h3f);
    chk("ovf_head_ts", bus.out_ts, 11);

    // Drain with en low (ts frozen at 0, prev frozen at 3f); p_in change ignored
    exp_d[0] = 6'h3f; exp_t[0] = 4'd11;
    exp_d[1] = 6'h00; exp_t[1] = 4'd12;
    exp_d[2] = 6'h3f; exp_t[2] = 4'd13;
    exp_d[3] = 6'h00; exp_t[3] = 4'd14;
    bus.en = 1'b0;
    bus.p_in = 6'h00;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", bus.out_valid, 1);
      chk("drain_data", bus.out_data, exp_d[i]);
      chk("drain_ts", bus.out_ts, exp_t[i]);
      tick();
    end
    chk("drained_valid", bus.out_valid, 0);
    chk("en_low_cnt", bus.chg_cnt, 7);
    tick();
    chk("ready_idle_valid", bus.out_valid, 0);
    chk("ovf_sticky", bus.ovf, 1);

    // Change every cycle for 20 cycles with ready high: ts wraps, cnt saturates
    bus.en = 1'b1;
    cnt = 7;
    for (int k = 0; k < 20; k++) begin
      bus.p_in = (k % 2 == 0) ? 6'h00 : 6'h3f;
      tick();
      if (cnt < 15) cnt++;
      chk("wrap_valid", bus.out_valid, 1);
      chk("wrap_data", bus.out_data, (k % 2 == 0) ? 32'h00 : 32'h3f);
      chk("wrap_ts", bus.out_ts, k % 16);
      chk("wrap_cnt", bus.chg_cnt, cnt);
    end
    tick();
    chk("wrap_end_valid", bus.out_valid, 0);
    chk("sat_cnt", bus.chg_cnt, 15);

    // Mid-run reset: queue 3 records (ts 5,6,7), then reset with a change present
    bus.out_ready = 1'b0;
    bus.p_in = 6'h00; tick();
    bus.p_in = 6'h3f; tick();
    bus.p_in = 6'h00; tick();
    chk("mid_valid", bus.out_valid, 1);
    chk("mid_data", bus.out_data, 6'h00);
    chk("mid_ts", bus.out_ts, 5);
    rst = 1'b1;
    bus.p_in = 6'h3f;
    tick();
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_data", bus.out_data, 0);
    chk("mrst_ts", bus.out_ts, 0);
    chk("mrst_cnt", bus.chg_cnt, 0);
    chk("mrst_ovf", bus.ovf, 0);

    // First post-reset sample compares against 0
    rst = 1'b0;
    tick();
    chk("post_valid", bus.out_valid, 1);
    chk("post_data", bus.out_data, 6'h3f);
    chk("post_ts", bus.out_ts, 0);
    chk("post_cnt", bus.chg_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
